// File: rtl/video_rx_pkg.sv
// Shared types and constants for the video receive monitor.
// Optional CRC feature is enabled with the VIDEO_RX_CRC_EN macro (see video_rx_monitor).
package video_rx_pkg;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SYNC,
    ST_ACTIVE
  } state_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Everything that crosses the synchronizer alongside the pixel clock.
  typedef struct packed {
    logic    hsync;
    logic    vsync;
    logic    de;
    rgb332_t pix;
  } vid_bundle_t;

  localparam int VID_W = $bits(vid_bundle_t);

  // CRC-8, MSB-first, one byte per call.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/video_rx_if.sv
// Parallel RGB332 video bus as seen on the self-test loopback.
interface video_rx_if;

  logic       video_clk;
  logic       video_hsync;
  logic       video_vsync;
  logic       video_de;
  logic [2:0] video_red;
  logic [2:0] video_green;
  logic [1:0] video_blue;

  modport master (
    output video_clk, video_hsync, video_vsync, video_de,
    output video_red, video_green, video_blue
  );

  modport slave (
    input video_clk, video_hsync, video_vsync, video_de,
    input video_red, video_green, video_blue
  );

endinterface

// File: rtl/video_rx_sync.sv
// Two-flop synchronizer for the video bundle plus pixel-clock rising-edge detect.
// The whole bundle moves together so data stays aligned with pix_evt_o.
module video_rx_sync
  import video_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        vclk_i,
  input  vid_bundle_t bundle_i,
  output vid_bundle_t bundle_o,
  output logic        pix_evt_o
);

  logic [VID_W:0] s1_q;
  logic [VID_W:0] s2_q;
  logic           vclk_prev_q;

  // Synchronizer chain and previous pixel-clock level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      vclk_prev_q <= 1'b0;
    end else begin
      s1_q        <= {vclk_i, bundle_i};
      s2_q        <= s1_q;
      vclk_prev_q <= s2_q[VID_W];
    end
  end

  assign bundle_o  = s2_q[VID_W-1:0];
  assign pix_evt_o = s2_q[VID_W] & ~vclk_prev_q;

endmodule

// File: rtl/video_rx_monitor.sv
// Receive-side geometry checker for the RGB332 display stream.
// Measures line length / frame height, tracks lock, sticky errors and a probe pixel.
// Define VIDEO_RX_CRC_EN to add a per-frame CRC-8 output (frame_crc).
module video_rx_monitor
  import video_rx_pkg::*;
#(
  parameter int   H_ACTIVE    = 800,
  parameter int   V_ACTIVE    = 600,
  parameter logic VSYNC_POL   = 1'b1,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic             clk_50M,
  input  logic             reset_btn,
  video_rx_if.slave        vid,
  input  logic [CNT_W-1:0] probe_x,
  input  logic [CNT_W-1:0] probe_y,
  output logic             locked,
  output logic             frame_done,
  output logic [CNT_W-1:0] pixel_count,
  output logic [CNT_W-1:0] line_count,
  output logic             err_h,
  output logic             err_v,
  output logic [7:0]       probe_pixel,
  output logic             probe_valid,
  output logic [7:0]       frame_cnt
`ifdef VIDEO_RX_CRC_EN
  ,
  output logic [7:0]       frame_crc
`endif
);

  localparam logic [CNT_W-1:0] H_EXP    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_EXP    = CNT_W'(V_ACTIVE);
  localparam logic [7:0]       LOCK_EXP = 8'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  vid_bundle_t vin, vsyn;
  logic        pix_evt;
  logic        vs_act, vs_rise, de_fall, de_pix;
  logic        hsync_unused;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic             line_bad_q, line_bad_d, hit_q, hit_d;
  rgb332_t          cap_q, cap_d;
  logic             vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
  logic [CNT_W-1:0] pixel_count_q, pixel_count_d, line_count_q, line_count_d;
  logic             err_h_q, err_h_d, err_v_q, err_v_d, locked_q, locked_d;
  logic [7:0]       good_cnt_q, good_cnt_d, probe_pixel_q, probe_pixel_d;
  logic             probe_valid_q, probe_valid_d, frame_done_q, frame_done_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
`ifdef VIDEO_RX_CRC_EN
  logic [7:0]       crc_q, crc_d, frame_crc_q, frame_crc_d;
`endif

  // Scratch values for the frame-end decision
  logic             take_pixel, bad_fin, frame_good;
  logic [CNT_W-1:0] y_fin;
  logic [7:0]       good_nxt;

  assign vin = {vid.video_hsync, vid.video_vsync, vid.video_de,
                vid.video_red, vid.video_green, vid.video_blue};

  video_rx_sync u_sync (
    .clk       (clk_50M),
    .rst       (reset_btn),
    .vclk_i    (vid.video_clk),
    .bundle_i  (vin),
    .bundle_o  (vsyn),
    .pix_evt_o (pix_evt)
  );

  // hsync travels through the synchronizer for alignment but is not checked
  assign hsync_unused = vsyn.hsync;

  assign vs_act  = (vsyn.vsync == VSYNC_POL);
  assign vs_rise = pix_evt & vs_act & ~vs_prev_q;
  assign de_fall = pix_evt & ~vsyn.de & de_prev_q;
  assign de_pix  = pix_evt & vsyn.de;

  // Next-state, counting and frame-end result computation
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    px_d          = px_q;
    py_d          = py_q;
    line_bad_d    = line_bad_q;
    hit_d         = hit_q;
    cap_d         = cap_q;
    vs_prev_d     = vs_prev_q;
    de_prev_d     = de_prev_q;
    pixel_count_d = pixel_count_q;
    line_count_d  = line_count_q;
    err_h_d       = err_h_q;
    err_v_d       = err_v_q;
    locked_d      = locked_q;
    good_cnt_d    = good_cnt_q;
    probe_pixel_d = probe_pixel_q;
    probe_valid_d = probe_valid_q;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = 1'b0;
`ifdef VIDEO_RX_CRC_EN
    crc_d         = crc_q;
    frame_crc_d   = frame_crc_q;
`endif
    take_pixel    = 1'b0;
    y_fin         = y_q;
    bad_fin       = line_bad_q;
    frame_good    = 1'b0;
    good_nxt      = '0;

    if (pix_evt) begin
      vs_prev_d = vs_act;
      de_prev_d = vsyn.de;
    end

    unique case (state_q)
      ST_SEARCH: begin
        if (vs_rise) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        // Held clear for the whole of SYNC; a pixel event is always at least
        // one cycle after entry, so the first active pixel sees zeroed state.
        x_d        = '0;
        y_d        = '0;
        line_bad_d = 1'b0;
        hit_d      = 1'b0;
        px_d       = probe_x;
        py_d       = probe_y;
`ifdef VIDEO_RX_CRC_EN
        crc_d      = '0;
`endif
        if (de_pix) begin
          state_d    = ST_ACTIVE;
          take_pixel = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          // A line ending on the vsync pixel is closed out first and counted
          if (de_fall) begin
            y_fin         = sat_inc(y_q);
            bad_fin       = line_bad_q | (x_q != H_EXP);
            pixel_count_d = x_q;
          end
          frame_good   = (y_fin == V_EXP) && !bad_fin;
          good_nxt     = !frame_good ? 8'd0 :
                         (good_cnt_q == LOCK_EXP) ? good_cnt_q : good_cnt_q + 8'd1;
          good_cnt_d   = good_nxt;
          locked_d     = frame_good && (good_nxt == LOCK_EXP);
          line_count_d = y_fin;
          err_h_d      = err_h_q | bad_fin;
          err_v_d      = err_v_q | (y_fin != V_EXP);
          probe_valid_d = hit_q;
          if (hit_q) probe_pixel_d = cap_q;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          frame_done_d = 1'b1;
`ifdef VIDEO_RX_CRC_EN
          frame_crc_d  = crc_q;
`endif
          state_d      = ST_SYNC;
        end else if (de_fall) begin
          pixel_count_d = x_q;
          if (x_q != H_EXP) line_bad_d = 1'b1;
          y_d = sat_inc(y_q);
          x_d = '0;
        end else if (de_pix) begin
          take_pixel = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    // Per-pixel work shared by the first pixel in SYNC and pixels in ACTIVE
    if (take_pixel) begin
      if ((x_q == px_q) && (y_q == py_q)) begin
        hit_d = 1'b1;
        cap_d = vsyn.pix;
      end
      x_d = sat_inc(x_q);
`ifdef VIDEO_RX_CRC_EN
      crc_d = crc8_update(crc_q, vsyn.pix);
`endif
    end
  end

  // State and result registers
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state_q       <= ST_SEARCH;
      x_q           <= '0;
      y_q           <= '0;
      px_q          <= '0;
      py_q          <= '0;
      line_bad_q    <= 1'b0;
      hit_q         <= 1'b0;
      cap_q         <= '0;
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      pixel_count_q <= '0;
      line_count_q  <= '0;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
      locked_q      <= 1'b0;
      good_cnt_q    <= '0;
      probe_pixel_q <= '0;
      probe_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
`ifdef VIDEO_RX_CRC_EN
      crc_q         <= '0;
      frame_crc_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      px_q          <= px_d;
      py_q          <= py_d;
      line_bad_q    <= line_bad_d;
      hit_q         <= hit_d;
      cap_q         <= cap_d;
      vs_prev_q     <= vs_prev_d;
      de_prev_q     <= de_prev_d;
      pixel_count_q <= pixel_count_d;
      line_count_q  <= line_count_d;
      err_h_q       <= err_h_d;
      err_v_q       <= err_v_d;
      locked_q      <= locked_d;
      good_cnt_q    <= good_cnt_d;
      probe_pixel_q <= probe_pixel_d;
      probe_valid_q <= probe_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_done_q  <= frame_done_d;
`ifdef VIDEO_RX_CRC_EN
      crc_q         <= crc_d;
      frame_crc_q   <= frame_crc_d;
`endif
    end
  end

  assign locked      = locked_q;
  assign frame_done  = frame_done_q;
  assign pixel_count = pixel_count_q;
  assign line_count  = line_count_q;
  assign err_h       = err_h_q;
  assign err_v       = err_v_q;
  assign probe_pixel = probe_pixel_q;
  assign probe_valid = probe_valid_q;
  assign frame_cnt   = frame_cnt_q;
`ifdef VIDEO_RX_CRC_EN
  assign frame_crc   = frame_crc_q;
`endif

endmodule

// File: tb/tb_video_rx_monitor.sv
// Scoreboard bench for video_rx_monitor with a 4x3 active geometry.
module tb_video_rx_monitor;

  logic clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic        reset_btn;
  logic [11:0] probe_x, probe_y;
  logic        locked, frame_done, err_h, err_v, probe_valid;
  logic [11:0] pixel_count, line_count;
  logic [7:0]  probe_pixel, frame_cnt;
`ifdef VIDEO_RX_CRC_EN
  logic [7:0]  frame_crc;
`endif

  video_rx_if vif();

  video_rx_monitor #(
    .H_ACTIVE    (4),
    .V_ACTIVE    (3),
    .VSYNC_POL   (1'b1),
    .LOCK_FRAMES (2)
  ) dut (
    .clk_50M     (clk_50M),
    .reset_btn   (reset_btn),
    .vid         (vif),
    .probe_x     (probe_x),
    .probe_y     (probe_y),
    .locked      (locked),
    .frame_done  (frame_done),
    .pixel_count (pixel_count),
    .line_count  (line_count),
    .err_h       (err_h),
    .err_v       (err_v),
    .probe_pixel (probe_pixel),
    .probe_valid (probe_valid),
    .frame_cnt   (frame_cnt)
`ifdef VIDEO_RX_CRC_EN
    ,
    .frame_crc   (frame_crc)
`endif
  );

  typedef struct {
    logic [11:0] pc;
    logic [11:0] lc;
    logic        lk;
    logic        eh;
    logic        ev;
    logic        pv;
    logic [7:0]  pp;
    logic [7:0]  fc;
    logic [7:0]  crc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         all_ones = 1'b0;
  logic [7:0] exp_fc = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Reference CRC-8/0x07, byte-at-a-time formulation
  function automatic logic [7:0] gold_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] pix_val(input int x, input int y);
    if (all_ones) return 8'h01;
    if (x == 2 && y == 1) return 8'hA5;
    return 8'((y << 4) | x);
  endfunction

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic pixel(input logic vs, input logic de, input logic [7:0] p);
    vif.video_clk   = 1'b0;
    vif.video_vsync = vs;
    vif.video_de    = de;
    vif.video_hsync = ~de & ~vs;
    {vif.video_red, vif.video_green, vif.video_blue} = p;
    tick();
    tick();
    vif.video_clk = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"},      32'(locked),      32'd0);
    chk({tag, "_frame_done"},  32'(frame_done),  32'd0);
    chk({tag, "_pixel_count"}, 32'(pixel_count), 32'd0);
    chk({tag, "_line_count"},  32'(line_count),  32'd0);
    chk({tag, "_err_h"},       32'(err_h),       32'd0);
    chk({tag, "_err_v"},       32'(err_v),       32'd0);
    chk({tag, "_probe_pixel"}, 32'(probe_pixel), 32'd0);
    chk({tag, "_probe_valid"}, 32'(probe_valid), 32'd0);
    chk({tag, "_frame_cnt"},   32'(frame_cnt),   32'd0);
`ifdef VIDEO_RX_CRC_EN
    chk({tag, "_frame_crc"},   32'(frame_crc),   32'd0);
`endif
  endtask

  // One frame of lines followed by the vsync pulse that closes it.
  // short_line gets 3 pixels; same_pix drops the blanking after the last line
  // so de falls on the vsync pixel; rst_line pulses reset inside that line.
  task automatic send_frame(input int nlines, input int short_line, input bit same_pix,
                            input int rst_line, input bit push,
                            input logic lk, input logic eh, input logic ev,
                            input logic pvld, input logic [7:0] pp);
    logic [7:0] gc;
    exp_t       e;
    int         np;
    gc = 8'h00;
    for (int y = 0; y < nlines; y++) begin
      np = (y == short_line) ? 3 : 4;
      for (int x = 0; x < np; x++) begin
        pixel(1'b0, 1'b1, pix_val(x, y));
        gc = gold_crc(gc, pix_val(x, y));
        if (y == rst_line && x == 1) begin
          reset_btn = 1'b1;
          tick();
          reset_btn = 1'b0;
          exp_fc = 8'd0;
          check_zero("midrst");
        end
      end
      if (!(same_pix && y == nlines - 1)) begin
        pixel(1'b0, 1'b0, 8'h00);
        pixel(1'b0, 1'b0, 8'h00);
      end
    end
    if (push) begin
      exp_fc = exp_fc + 8'd1;
      e.pc  = 12'd4;
      e.lc  = 12'(nlines);
      e.lk  = lk;
      e.eh  = eh;
      e.ev  = ev;
      e.pv  = pvld;
      e.pp  = pp;
      e.fc  = exp_fc;
      e.crc = gc;
      sb_q.push_back(e);
    end
    pixel(1'b1, 1'b0, 8'h00);
    pixel(1'b1, 1'b0, 8'h00);
    pixel(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: every frame_done pulse is matched against the oldest expectation
  always @(negedge clk_50M) begin
    exp_t e;
    if (frame_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame_done: got frame_cnt 0x%0h expected no frame end", frame_cnt);
      end else begin
        e = sb_q.pop_front();
        chk("pixel_count", 32'(pixel_count), 32'(e.pc));
        chk("line_count",  32'(line_count),  32'(e.lc));
        chk("locked",      32'(locked),      32'(e.lk));
        chk("err_h",       32'(err_h),       32'(e.eh));
        chk("err_v",       32'(err_v),       32'(e.ev));
        chk("probe_valid", 32'(probe_valid), 32'(e.pv));
        if (e.pv) chk("probe_pixel", 32'(probe_pixel), 32'(e.pp));
        chk("frame_cnt",   32'(frame_cnt),   32'(e.fc));
`ifdef VIDEO_RX_CRC_EN
        chk("frame_crc",   32'(frame_crc),   32'(e.crc));
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ones_crc;
    reset_btn       = 1'b1;
    probe_x         = 12'd2;
    probe_y         = 12'd1;
    vif.video_clk   = 1'b0;
    vif.video_hsync = 1'b0;
    vif.video_vsync = 1'b0;
    vif.video_de    = 1'b0;
    vif.video_red   = 3'd0;
    vif.video_green = 3'd0;
    vif.video_blue  = 2'd0;
    repeat (3) tick();
    reset_btn = 1'b0;
    tick();
    check_zero("reset");

    // Leading vsync moves the monitor from SEARCH to SYNC
    pixel(1'b1, 1'b0, 8'h00);
    pixel(1'b1, 1'b0, 8'h00);
    pixel(1'b0, 1'b0, 8'h00);

    //          lines short same rst push  lk    eh    ev    pv    pp
    send_frame(3, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    send_frame(3, -1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
    send_frame(3, -1, 1'b1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
    send_frame(3,  1, 1'b0, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
    send_frame(3, -1, 1'b0, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
    send_frame(3, -1, 1'b1, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
    send_frame(4, -1, 1'b0, -1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
    probe_x = 12'd9;
    send_frame(3, -1, 1'b0, -1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    probe_x = 12'd2;
    // Partial frame cut by reset: no frame end expected, next vsync only resyncs
    send_frame(3, -1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    all_ones = 1'b1;
    send_frame(3, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    send_frame(3, -1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    chk("frames_pending", 32'(sb_q.size()), 32'd0);

`ifdef VIDEO_RX_CRC_EN
    ones_crc = 8'h00;
    for (int i = 0; i < 12; i++) ones_crc = gold_crc(ones_crc, 8'h01);
    chk("frame_crc_ones", 32'(frame_crc), 32'(ones_crc));
`else
    ones_crc = 8'h00;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
